// File: rtl/lcd_refresh_sequencer_pkg.sv
// Shared definitions for the LCD refresh sequencer.
//  - HD44780 command bytes used during init and row addressing
//  - sequencer and strobe state encodings
//  - helpers that pick an init byte and a character out of a 128-bit row
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment cursor, no shift
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_ROW0     = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_ROW1     = 8'hC0;  // DDRAM address 0x40

    localparam int DELAY_W = 20;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_N,
        INIT_B,
        IDLE,
        ADDR0,
        ROW0,
        ADDR1,
        ROW1
    } seq_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_DELAY
    } strobe_phase_t;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNC_SET;
            2'd1:    b = LCD_ENTRY;
            2'd2:    b = LCD_DISP_ON;
            default: b = LCD_CLEAR;
        endcase
        return b;
    endfunction

    // Column 0 sits in the top byte, so the byte offset is (15 - col),
    // which for a 4-bit column is simply ~col.
    function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] col);
        return row[{~col, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_if.sv
// Bundle between the row-buffer producer and the LCD pins.
//  master : the sequencer (reads rows/refresh_en, drives LCD pins and status)
//  slave  : the surrounding logic (drives rows/refresh_en, observes pins and status)
interface lcd_refresh_sequencer_if;
    logic [127:0] upper_row;
    logic [127:0] lower_row;
    logic         refresh_en;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [3:0]   nibble;
    logic         init_done;
    logic         frame_done;

    modport master (
        input  upper_row, lower_row, refresh_en,
        output lcd_e, lcd_rs, lcd_rw, nibble, init_done, frame_done
    );

    modport slave (
        output upper_row, lower_row, refresh_en,
        input  lcd_e, lcd_rs, lcd_rw, nibble, init_done, frame_done
    );
endinterface

// File: rtl/lcd_refresh_sequencer_strobe.sv
// One LCD bus write: setup, enable-high, hold, then a programmable post delay.
// Ports:
//  clk, rst             clock, asynchronous active-high reset
//  go                   request a strobe (taken when idle or on the last delay cycle)
//  nib_in, rs_in        nibble and register select for the strobe
//  post_delay           cycles to wait after the hold phase
//  busy                 a strobe or its delay is in progress
//  done                 one-cycle pulse on the last post-delay cycle
//  lcd_e, lcd_rs, nibble  LCD pins
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12,
    parameter int T_HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [3:0]         nib_in,
    input  logic               rs_in,
    input  logic [DELAY_W-1:0] post_delay,
    output logic               busy,
    output logic               done,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic [3:0]         nibble
);

    localparam logic [DELAY_W-1:0] C_SETUP = DELAY_W'(T_SETUP - 1);
    localparam logic [DELAY_W-1:0] C_EHIGH = DELAY_W'(T_EHIGH - 1);
    localparam logic [DELAY_W-1:0] C_HOLD  = DELAY_W'(T_HOLD - 1);

    strobe_phase_t      phase_reg, phase_next;
    logic [DELAY_W-1:0] cnt_reg, cnt_next;
    logic [DELAY_W-1:0] delay_reg;
    logic [3:0]         nib_reg;
    logic               rs_reg;
    logic               accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= S_IDLE;
            cnt_reg   <= '0;
            delay_reg <= '0;
            nib_reg   <= 4'h0;
            rs_reg    <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                nib_reg   <= nib_in;
                rs_reg    <= rs_in;
                delay_reg <= post_delay;
            end
        end
    end

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        case (phase_reg)
            S_SETUP: begin
                if (cnt_reg == '0) begin
                    phase_next = S_EHIGH;
                    cnt_next   = C_EHIGH;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_EHIGH: begin
                if (cnt_reg == '0) begin
                    phase_next = S_HOLD;
                    cnt_next   = C_HOLD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_reg == '0) begin
                    phase_next = S_DELAY;
                    // a zero post delay still costs one cycle
                    cnt_next   = (delay_reg == '0) ? '0 : delay_reg - 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_reg == '0) begin
                    phase_next = S_IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: ;
        endcase
        // Taking the next request on the last delay cycle makes the gap
        // between strobes exactly the requested post delay.
        accept = go && ((phase_reg == S_IDLE) || done);
        if (accept) begin
            phase_next = S_SETUP;
            cnt_next   = C_SETUP;
        end
    end

    assign busy   = (phase_reg != S_IDLE);
    assign lcd_e  = (phase_reg == S_EHIGH);
    assign lcd_rs = rs_reg;
    assign nibble = nib_reg;

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Power-up/init and continuous two-row refresh of a 16x2 HD44780 LCD on its 4-bit bus.
// Ports:
//  clk   system clock
//  rst   asynchronous active-high reset; restarts the full power-up sequence
//  bus   lcd_refresh_sequencer_if.master: rows, refresh_en in; LCD pins, init_done, frame_done out
// Each frame is taken from shadow copies of the rows latched in IDLE, so text
// changing at the inputs mid-frame only shows up in the following frame.
module lcd_refresh_sequencer
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_NIB     = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_SETUP   = 2,
    parameter int T_EHIGH   = 12,
    parameter int T_HOLD    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    lcd_refresh_sequencer_if.master bus
);

    localparam logic [DELAY_W-1:0] D_PWR_LAST = DELAY_W'(T_POWERUP - 1);
    localparam logic [DELAY_W-1:0] D_INIT1    = DELAY_W'(T_INIT1);
    localparam logic [DELAY_W-1:0] D_INIT2    = DELAY_W'(T_INIT2);
    localparam logic [DELAY_W-1:0] D_NIB      = DELAY_W'(T_NIB);
    localparam logic [DELAY_W-1:0] D_CMD      = DELAY_W'(T_CMD);
    localparam logic [DELAY_W-1:0] D_CLEAR    = DELAY_W'(T_CLEAR);

    seq_state_t         state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;         // init nibble / init byte index
    logic [3:0]         col_reg, col_next;
    logic               nib_sel_reg, nib_sel_next; // 0 = high nibble, 1 = low nibble
    logic               drain_reg, drain_next;     // last byte issued, waiting for its delay
    logic [DELAY_W-1:0] pwr_cnt_reg, pwr_cnt_next;
    logic [127:0]       row0_reg, row0_next;
    logic [127:0]       row1_reg, row1_next;
    logic               init_done_reg, init_done_next;
    logic               frame_done_reg, frame_done_next;

    logic               go;
    logic [3:0]         go_nib;
    logic               go_rs;
    logic [DELAY_W-1:0] go_delay;
    logic [7:0]         cur_byte;
    logic               stb_busy, stb_done, stb_ready;

    lcd_strobe #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_HOLD  (T_HOLD)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .nib_in     (go_nib),
        .rs_in      (go_rs),
        .post_delay (go_delay),
        .busy       (stb_busy),
        .done       (stb_done),
        .lcd_e      (bus.lcd_e),
        .lcd_rs     (bus.lcd_rs),
        .nibble     (bus.nibble)
    );

    // A request is taken exactly when the strobe can accept it, so the
    // sequencer advances to the next nibble on acceptance, not on completion.
    assign stb_ready = !stb_busy || stb_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= PWRUP;
            idx_reg        <= 2'd0;
            col_reg        <= 4'd0;
            nib_sel_reg    <= 1'b0;
            drain_reg      <= 1'b0;
            pwr_cnt_reg    <= '0;
            row0_reg       <= '0;
            row1_reg       <= '0;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            col_reg        <= col_next;
            nib_sel_reg    <= nib_sel_next;
            drain_reg      <= drain_next;
            pwr_cnt_reg    <= pwr_cnt_next;
            row0_reg       <= row0_next;
            row1_reg       <= row1_next;
            init_done_reg  <= init_done_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        col_next        = col_reg;
        nib_sel_next    = nib_sel_reg;
        drain_next      = drain_reg;
        pwr_cnt_next    = pwr_cnt_reg;
        row0_next       = row0_reg;
        row1_next       = row1_reg;
        init_done_next  = init_done_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            INIT_B:  cur_byte = init_byte(idx_reg);
            ADDR0:   cur_byte = LCD_ROW0;
            ROW0:    cur_byte = row_char(row0_reg, col_reg);
            ADDR1:   cur_byte = LCD_ROW1;
            ROW1:    cur_byte = row_char(row1_reg, col_reg);
            default: cur_byte = 8'h00;
        endcase

        go       = 1'b0;
        go_rs    = (state_reg == ROW0) || (state_reg == ROW1);
        go_nib   = nib_sel_reg ? cur_byte[3:0] : cur_byte[7:4];
        go_delay = nib_sel_reg ? ((cur_byte == LCD_CLEAR) ? D_CLEAR : D_CMD) : D_NIB;

        case (state_reg)
            PWRUP: begin
                if (pwr_cnt_reg == D_PWR_LAST) begin
                    pwr_cnt_next = '0;
                    state_next   = INIT_N;
                end else begin
                    pwr_cnt_next = pwr_cnt_reg + 1'b1;
                end
            end
            INIT_N: begin
                // wake-up nibbles 3,3,3 then 2 switches the controller to 4-bit mode
                go       = 1'b1;
                go_nib   = (idx_reg == 2'd3) ? 4'h2 : 4'h3;
                go_delay = (idx_reg == 2'd0) ? D_INIT1 : D_INIT2;
                if (stb_ready) begin
                    if (idx_reg == 2'd3) begin
                        idx_next     = 2'd0;
                        nib_sel_next = 1'b0;
                        state_next   = INIT_B;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (bus.refresh_en) begin
                    row0_next  = bus.upper_row;
                    row1_next  = bus.lower_row;
                    col_next   = 4'd0;
                    state_next = ADDR0;
                end
            end
            default: begin
                if (drain_reg) begin
                    // the final byte of init or of a frame has been handed over;
                    // report completion only once its post delay has elapsed
                    if (stb_ready) begin
                        drain_next = 1'b0;
                        state_next = IDLE;
                        if (state_reg == INIT_B) begin
                            init_done_next = 1'b1;
                            idx_next       = 2'd0;
                        end else begin
                            frame_done_next = 1'b1;
                        end
                    end
                end else begin
                    go = 1'b1;
                    if (stb_ready) begin
                        if (!nib_sel_reg) begin
                            nib_sel_next = 1'b1;
                        end else begin
                            nib_sel_next = 1'b0;
                            case (state_reg)
                                INIT_B: begin
                                    if (idx_reg == 2'd3) drain_next = 1'b1;
                                    else                 idx_next   = idx_reg + 1'b1;
                                end
                                ADDR0: begin
                                    col_next   = 4'd0;
                                    state_next = ROW0;
                                end
                                ROW0: begin
                                    col_next = col_reg + 1'b1;
                                    if (col_reg == 4'd15) state_next = ADDR1;
                                end
                                ADDR1: begin
                                    col_next   = 4'd0;
                                    state_next = ROW1;
                                end
                                ROW1: begin
                                    col_next = col_reg + 1'b1;
                                    if (col_reg == 4'd15) drain_next = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    assign bus.lcd_rw     = 1'b0;
    assign bus.init_done  = init_done_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Self-checking bench for lcd_refresh_sequencer with shortened delays.
// A negedge monitor compares every strobe against an expected-strobe queue
// built from the LCD protocol (init list, then 0x80 + row 0 + 0xC0 + row 1
// taken from the rows present when each frame begins) and checks strobe
// shape and inter-strobe gaps. The main process drives directed and random rows.
module tb_lcd_refresh_sequencer;

    localparam int P_POWERUP = 20;
    localparam int P_INIT1   = 10;
    localparam int P_INIT2   = 5;
    localparam int P_NIB     = 3;
    localparam int P_CMD     = 6;
    localparam int P_CLEAR   = 12;
    localparam int P_SETUP   = 2;
    localparam int P_EHIGH   = 12;
    localparam int P_HOLD    = 2;

    typedef struct packed {
        logic        rs;
        logic [3:0]  nib;
        logic [31:0] delay;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_refresh_sequencer_if bus ();

    lcd_refresh_sequencer #(
        .T_POWERUP (P_POWERUP),
        .T_INIT1   (P_INIT1),
        .T_INIT2   (P_INIT2),
        .T_NIB     (P_NIB),
        .T_CMD     (P_CMD),
        .T_CLEAR   (P_CLEAR),
        .T_SETUP   (P_SETUP),
        .T_EHIGH   (P_EHIGH),
        .T_HOLD    (P_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    item_t exp_q[$];

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back('{rs: rs, nib: b[7:4], delay: P_NIB});
        exp_q.push_back('{rs: rs, nib: b[3:0], delay: (b == 8'h01) ? P_CLEAR : P_CMD});
    endtask

    task automatic push_init();
        exp_q.push_back('{rs: 1'b0, nib: 4'h3, delay: P_INIT1});
        exp_q.push_back('{rs: 1'b0, nib: 4'h3, delay: P_INIT2});
        exp_q.push_back('{rs: 1'b0, nib: 4'h3, delay: P_INIT2});
        exp_q.push_back('{rs: 1'b0, nib: 4'h2, delay: P_INIT2});
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [127:0] up, input logic [127:0] lo);
        push_byte(1'b0, 8'h80);
        for (int c = 0; c < 16; c++) push_byte(1'b1, up[127 - 8*c -: 8]);
        push_byte(1'b0, 8'hC0);
        for (int c = 0; c < 16; c++) push_byte(1'b1, lo[127 - 8*c -: 8]);
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    // ---------------- monitor ----------------
    int    strobes = 0;
    int    frames = 0;
    int    frame_pos = 0;
    int    high_run = 0;
    int    low_run = 0;
    int    hold_left = 0;
    int    prev_delay = 0;
    bit    prev_valid = 0;
    bit    need_init = 1;
    bit    seen_init_done = 0;
    bit    fd_prev = 0;
    logic  prev_e = 1'b0;
    logic [4:0] cur = '0, hist0 = '0, hist1 = '0, held = '0;
    item_t it;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            need_init      = 1;
            prev_valid     = 0;
            seen_init_done = 0;
            frame_pos      = 0;
            high_run       = 0;
            low_run        = 0;
            hold_left      = 0;
            prev_e         = 1'b0;
            fd_prev        = 0;
            hist0          = '0;
            hist1          = '0;
        end else begin
            if (need_init) begin
                push_init();
                need_init = 0;
            end
            cur = {bus.lcd_rs, bus.nibble};
            if (bus.lcd_e && !prev_e) begin
                check("setup_stable", {27'd0, hist1}, {27'd0, hist0});
                check("setup_value", {27'd0, hist0}, {27'd0, cur});
                check("lcd_rw", {31'd0, bus.lcd_rw}, 32'd0);
                if (prev_valid) check("gap", low_run, P_HOLD + prev_delay + P_SETUP);
                if (exp_q.size() == 0) begin
                    if (seen_init_done) begin
                        push_frame(bus.upper_row, bus.lower_row);
                        frame_pos = 0;
                    end else begin
                        check("spare_strobe", 32'd1, 32'd0);
                    end
                end
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("rs", {31'd0, bus.lcd_rs}, {31'd0, it.rs});
                    check("nibble", {28'd0, bus.nibble}, {28'd0, it.nib});
                    prev_delay = int'(it.delay);
                    prev_valid = 1;
                end
                strobes++;
                if (seen_init_done) frame_pos++;
                $display("strobe %0d: rs=%0d nibble=%h frame_pos=%0d", strobes, bus.lcd_rs, bus.nibble, frame_pos);
            end
            if (!bus.lcd_e && prev_e) begin
                check("e_width", high_run, P_EHIGH);
                hold_left = P_HOLD;
                held      = hist0;
            end
            if (!bus.lcd_e && hold_left > 0) begin
                check("hold", {27'd0, cur}, {27'd0, held});
                hold_left--;
            end
            if (bus.init_done && !seen_init_done) begin
                check("init_done_delay", low_run, P_HOLD + P_CLEAR);
                check("init_all_sent", exp_q.size(), 32'd0);
                seen_init_done = 1;
                prev_valid     = 0;
                $display("init_done after %0d strobes", strobes);
            end
            if (bus.frame_done) begin
                check("frame_all_sent", exp_q.size(), 32'd0);
                check("frame_pulse_width", {31'd0, fd_prev}, 32'd0);
                check("frame_init_high", {31'd0, bus.init_done}, 32'd1);
                frames++;
                frame_pos  = 0;
                prev_valid = 0;
                $display("frame_done %0d", frames);
            end
            if (bus.lcd_e) begin
                high_run = prev_e ? high_run + 1 : 1;
                low_run  = 0;
            end else begin
                low_run++;
            end
            hist1   = hist0;
            hist0   = cur;
            prev_e  = bus.lcd_e;
            fd_prev = bus.frame_done;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", {31'd0, frames >= target}, 32'd1);
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        while (frame_pos < pos && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("pos_timeout", {31'd0, frame_pos >= pos}, 32'd1);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!bus.init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("init_timeout", {31'd0, bus.init_done}, 32'd1);
    endtask

    // Release reset and measure the quiet time before the first enable pulse:
    // the slot starts T_POWERUP cycles after release, lcd_e follows T_SETUP later.
    task automatic release_and_check_powerup();
        int n = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        do begin
            @(negedge clk);
            if (!bus.lcd_e) n++;
        end while (!bus.lcd_e && n < 200);
        check("powerup_quiet", n, P_POWERUP + P_SETUP);
        check("first_nibble", {28'd0, bus.nibble}, 32'd3);
        check("first_rs", {31'd0, bus.lcd_rs}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.refresh_en = 1'b0;
        bus.upper_row  = "0123456789ABCDEF";
        bus.lower_row  = "TIME 05:00      ";
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {22'd0, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.nibble, bus.init_done, bus.frame_done},
              32'd0);

        release_and_check_powerup();
        wait_init();

        // refresh disabled: IDLE must stay quiet
        n = strobes;
        repeat (60) @(negedge clk);
        check("idle_quiet", strobes, n);

        // directed frame with the reference strings
        bus.refresh_en = 1'b1;
        wait_frames(frames + 1);

        // text change after the 4th ROW0 char: current frame keeps old text
        wait_pos(2 + 8);
        bus.upper_row = {16{8'h58}};
        wait_frames(frames + 1);
        wait_frames(frames + 1);

        // random text changes at random points inside frames
        for (int k = 0; k < 4; k++) begin
            wait_pos($urandom_range(1, 60));
            bus.upper_row = rand_row();
            bus.lower_row = rand_row();
            wait_frames(frames + 1);
        end

        // drop refresh_en mid-ROW0: the frame completes, then silence
        wait_pos(12);
        bus.refresh_en = 1'b0;
        wait_frames(frames + 1);
        n = strobes;
        repeat (300) @(negedge clk);
        check("stop_quiet", strobes, n);
        bus.refresh_en = 1'b1;
        wait_frames(frames + 1);

        // reset while lcd_e is high in ROW1
        n = 0;
        while (!(frame_pos >= 40 && bus.lcd_e) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("row1_strobe_found", {31'd0, bus.lcd_e}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {25'd0, bus.lcd_e, bus.lcd_rs, bus.nibble, bus.init_done},
              32'd0);
        repeat (2) @(negedge clk);
        release_and_check_powerup();
        wait_init();
        wait_frames(frames + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
